bitwise_logic_pipe: RTL and testbench
=====================================

Name: bitwise_logic_pipe

Overview:
- Parametrised, pipelined successor to the fixed 32-bit single-function AND array.
- Applies one of several bitwise operations to three WIDTH-bit operands: AND, OR, XOR, NOT, ANDN, SHA-256 Ch, Maj and XOR3.
- Two register stages with a valid/ready handshake and full backpressure.
- Feeds the SHA-256 round datapath of the miner and keeps a saturating count of completed operations.

Parameters:
- WIDTH, 32, operand and result width in bits (legal range 1 to 64).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clock  in  1  rising-edge clock; the only clock in the block.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block accepts the input this cycle.
- in_op  in  4  operation select.
- in_x  in  WIDTH  operand X.
- in_y  in  WIDTH  operand Y.
- in_z  in  WIDTH  operand Z.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_err  out  1  in_op was an illegal code; out_data is 0.
- busy  out  1  at least one transaction is held in stage 1 or stage 2.
- op_count  out  CNT_W  completed output handshakes, saturating.

Behaviour:
- Reset: when reset_n is low at a clock edge, all of the following are cleared, and clearing takes priority over any handshake in that cycle:
  - s1_valid, out_valid, out_err, out_data, op_count and all stage-1 registers clear to 0.
  - in_ready goes to 1 in the next cycle.
- Reset arriving mid-operation discards all in-flight data; no handshake completes on the reset edge.
- Op codes:
  - 0 AND: x&y.
  - 1 OR: x|y.
  - 2 XOR: x^y.
  - 3 NOT: ~x.
  - 4 ANDN: x&~y.
  - 5 CH: (x&y)^(~x&z).
  - 6 MAJ: (x&y)^(x&z)^(y&z).
  - 7 XOR3: x^y^z.
  - 8-15: illegal, except as defined under Optional Feature. An illegal op gives out_data=0 and out_err=1, and still counts as a transaction.
- Unused operands are don't-care.
- Stage 1 registers op/x/y/z and s1_valid.
- Stage 2 computes the result from the stage-1 registers and registers out_data, out_err and out_valid.
- Stall and ready:
  - Define adv2 = !out_valid | out_ready.
  - in_ready = !s1_valid | adv2. This is purely combinational from registered state plus out_ready, with no dependence on in_valid.
- Input accept = in_valid & in_ready. Stage 1 loads on accept. If adv2 holds and there is no accept, s1_valid clears.
- Stage 2 update when adv2 holds:
  - out_valid <= s1_valid.
  - out_data and out_err load only when s1_valid=1.
- When adv2 is low, out_data and out_err are held unchanged.
- Latency: a result appears 2 cycles after acceptance when the pipe is not stalled. Throughput is 1 per cycle with out_ready held at 1.
- Ordering is strictly FIFO, and no transaction is ever dropped or duplicated.
- Simultaneous events: with both stages full and out_ready=1, output, stage-2 load and stage-1 load all occur in the same cycle.
- busy = s1_valid | out_valid.
- op_count increments on each out_valid & out_ready and holds at all-ones (saturates).

Optional Feature:
- Macro BITWISE_SIGMA_EN.
- When defined, two further codes are legal. Both require WIDTH=32; elaboration fails otherwise.
  - 8 SIG0: ROTR2(x)^ROTR13(x)^ROTR22(x).
  - 9 SIG1: ROTR6(x)^ROTR11(x)^ROTR25(x).
- When undefined, codes 8 and 9 are illegal (out_err=1, out_data=0). No rotation logic is generated.

Decomposition:
- Shared package bitwise_pkg holds the op-code localparams (OP_AND through OP_SIG1) and the op-select width constant (4).
- One combinational sub-module, bitwise_logic_core: inputs op, x, y, z; outputs result and err. It is instantiated in stage 2.
- The handshake, pipeline registers and counter stay in bitwise_logic_pipe.

Test Plan:
- Reset and AND:
  - Stimulus: hold reset_n=0 for 2 cycles, release; send op0 with x=F0F0F0F0, y=FF00FF00, out_ready=1.
  - Required: out_valid rises 2 cycles after acceptance with out_data=F000F000, out_err=0, op_count=1.
- CH and MAJ:
  - Stimulus: x=FFFF0000, y=12345678, z=9ABCDEF0.
  - Required: op5 gives 1234DEF0; op6 gives 9ABCDEF0 & FFFF0000 | … per reference model; compare bit-exact.
- Backpressure:
  - Stimulus: stream 6 transactions with out_ready=0 for 5 cycles.
  - Required: in_ready falls after 2 accepts; all 6 results emerge in order after out_ready=1; none lost; op_count=6.
- Illegal op:
  - Stimulus: op=12, or op=8 with the macro undefined.
  - Required: out_data=0, out_err=1, counted; the next legal op clears out_err.
- Reset mid-stream:
  - Stimulus: 2 in flight with out_ready=0; pulse reset_n=0 for one cycle.
  - Required: out_valid=0, busy=0, op_count=0 in the next cycle; no stale output afterwards.
- Sigma and saturation:
  - Stimulus: with BITWISE_SIGMA_EN defined, op8 with x=6A09E667; separately, run with CNT_W=3 through 10 transactions.
  - Required: op8 gives CE20B47E; op_count stops at 7.

Source files
------------

// File: rtl/bitwise_logic_pipe_pkg.sv
// Shared op-code definitions for the bitwise logic pipe.
// Codes 8/9 (SIG0/SIG1) are only legal when BITWISE_SIGMA_EN is defined.
package bitwise_pkg;

  localparam int unsigned OP_W = 4;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_AND  = 4'd0;
  localparam op_t OP_OR   = 4'd1;
  localparam op_t OP_XOR  = 4'd2;
  localparam op_t OP_NOT  = 4'd3;
  localparam op_t OP_ANDN = 4'd4;
  localparam op_t OP_CH   = 4'd5;
  localparam op_t OP_MAJ  = 4'd6;
  localparam op_t OP_XOR3 = 4'd7;
  localparam op_t OP_SIG0 = 4'd8;
  localparam op_t OP_SIG1 = 4'd9;

endpackage

// File: rtl/bitwise_logic_pipe_if.sv
// Valid/ready request and response bus of the bitwise logic pipe.
interface bitwise_logic_pipe_if #(
  parameter int unsigned WIDTH = 32
) ();
  import bitwise_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_t              in_op;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [WIDTH-1:0] in_z;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  // Producer / consumer side (testbench, upstream datapath)
  modport master (
    output in_valid, in_op, in_x, in_y, in_z, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  // Pipe side
  modport slave (
    input  in_valid, in_op, in_x, in_y, in_z, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/bitwise_logic_pipe_core.sv
// Combinational bitwise operation unit used in stage 2.
// Optional macro BITWISE_SIGMA_EN adds SHA-256 SIG0/SIG1 (WIDTH must be 32).
module bitwise_logic_core
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] result,
  output logic             err
);

`ifdef BITWISE_SIGMA_EN
  if (WIDTH != 32) begin : g_sigma_width_chk
    $error("bitwise_logic_core: BITWISE_SIGMA_EN requires WIDTH == 32");
  end

  function automatic logic [31:0] rotr(input logic [31:0] v, input int unsigned n);
    return (v >> n) | (v << (32 - n));
  endfunction

  logic [31:0] x32_c;
  logic [31:0] sig0_c;
  logic [31:0] sig1_c;

  // SHA-256 big-sigma rotations of operand X
  assign x32_c  = 32'(x);
  assign sig0_c = rotr(x32_c, 2) ^ rotr(x32_c, 13) ^ rotr(x32_c, 22);
  assign sig1_c = rotr(x32_c, 6) ^ rotr(x32_c, 11) ^ rotr(x32_c, 25);
`endif

  // Operation select; unknown codes yield zero with err set
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_AND:  result = x & y;
      OP_OR:   result = x | y;
      OP_XOR:  result = x ^ y;
      OP_NOT:  result = ~x;
      OP_ANDN: result = x & ~y;
      OP_CH:   result = (x & y) ^ (~x & z);
      OP_MAJ:  result = (x & y) ^ (x & z) ^ (y & z);
      OP_XOR3: result = x ^ y ^ z;
`ifdef BITWISE_SIGMA_EN
      OP_SIG0: result = WIDTH'(sig0_c);
      OP_SIG1: result = WIDTH'(sig1_c);
`endif
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready bitwise logic pipe with saturating completion counter.
// Optional macro BITWISE_SIGMA_EN enables SIG0/SIG1 in the core.
module bitwise_logic_pipe
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  bitwise_logic_pipe_if.slave  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  logic             s1_valid_q, s1_valid_d;
  op_t              s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_x_q,     s1_x_d;
  logic [WIDTH-1:0] s1_y_q,     s1_y_d;
  logic [WIDTH-1:0] s1_z_q,     s1_z_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_err_q,   out_err_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic             adv2_c;
  logic             in_ready_c;
  logic             accept_c;
  logic [WIDTH-1:0] core_result_c;
  logic             core_err_c;

  // Stage 2 can take new data when empty or when its result leaves this cycle
  assign adv2_c     = !out_valid_q | bus.out_ready;
  assign in_ready_c = !s1_valid_q | adv2_c;
  assign accept_c   = bus.in_valid & in_ready_c;

  bitwise_logic_core #(.WIDTH(WIDTH)) u_core (
    .op     (s1_op_q),
    .x      (s1_x_q),
    .y      (s1_y_q),
    .z      (s1_z_q),
    .result (core_result_c),
    .err    (core_err_c)
  );

  // Next-state for both pipeline stages and the completion counter
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_z_d      = s1_z_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    cnt_d       = cnt_q;

    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_op_d    = bus.in_op;
      s1_x_d     = bus.in_x;
      s1_y_d     = bus.in_y;
      s1_z_d     = bus.in_z;
    end else if (adv2_c) begin
      s1_valid_d = 1'b0;
    end

    if (adv2_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = core_result_c;
        out_err_d  = core_err_c;
      end
    end

    if (out_valid_q && bus.out_ready && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and counter registers; reset wins over any handshake
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_z_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_z_q      <= s1_z_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign busy          = s1_valid_q | out_valid_q;
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard testbench for bitwise_logic_pipe (main instance plus a CNT_W=3 instance).
module tb_bitwise_logic_pipe;
  import bitwise_pkg::*;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  typedef struct packed {
    op_t          op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic [W-1:0] ed;
    logic         ee;
  } vec_t;

`ifdef BITWISE_SIGMA_EN
  localparam logic [W-1:0] SIG0_EXP = 32'hCE20B47E;
  localparam logic         SIG0_ERR = 1'b0;
`else
  localparam logic [W-1:0] SIG0_EXP = 32'h00000000;
  localparam logic         SIG0_ERR = 1'b1;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bitwise_logic_pipe_if #(.WIDTH(W)) bus ();
  bitwise_logic_pipe_if #(.WIDTH(W)) sif ();
  logic        busy;
  logic [15:0] op_count;
  logic        sat_busy;
  logic [2:0]  sat_count;

  bitwise_logic_pipe #(.WIDTH(W), .CNT_W(16)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  bitwise_logic_pipe #(.WIDTH(W), .CNT_W(3)) dut_sat (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (sif),
    .busy     (sat_busy),
    .op_count (sat_count)
  );

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;

  vec_t vecs [12] = '{
    '{OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 32'hFFF0FFF0, 1'b0},
    '{OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 32'h0FF00FF0, 1'b0},
    '{OP_NOT,   32'hF0F0F0F0, 32'h12345678, 32'h00000000, 32'h0F0F0F0F, 1'b0},
    '{OP_ANDN,  32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 32'h00F000F0, 1'b0},
    '{OP_XOR3,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00FF00FF, 1'b0},
    '{OP_CH,    32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0, 32'h1234DEF0, 1'b0},
    '{OP_MAJ,   32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0, 32'h9ABC5670, 1'b0},
    '{4'd12,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1},
    '{OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 32'hF000F000, 1'b0},
    '{OP_SIG0,  32'h6A09E667, 32'h00000000, 32'h00000000, SIG0_EXP,     SIG0_ERR},
    '{4'd15,    32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'h00000000, 1'b1},
    '{OP_XOR3,  32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 32'h00000000, 1'b0}
  };

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pop and compare on every completed output handshake
  always @(negedge clock) begin
    #2;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %h err %b expected no output", bus.out_data, bus.out_err);
      end else begin
        mon_e = q.pop_front();
        check("out_data", bus.out_data, mon_e.data);
        check("out_err", W'(bus.out_err), W'(mon_e.err));
      end
    end
  end

  // Issue one transaction and record its expected result at acceptance
  task automatic send(input op_t op, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] z, input logic [W-1:0] ed, input logic ee);
    bit acc;
    acc = 1'b0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_z     = z;
    for (int c = 0; c < 50; c++) begin
      #1;
      acc = bus.in_ready;
      if (acc) begin
        q.push_back('{data: ed, err: ee});
        n_acc++;
      end
      @(posedge clock);
      if (acc) break;
      @(negedge clock);
    end
    #1;
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected accept within 50 cycles");
    end
  endtask

  // Wait until every expected result has emerged and the pipe is idle
  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #3;
      if (q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", W'(ok), W'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_z      = '0;
    bus.out_ready = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_op     = OP_AND;
    sif.in_x      = 32'hFFFFFFFF;
    sif.in_y      = 32'h0F0F0F0F;
    sif.in_z      = '0;
    sif.out_ready = 1'b1;

    // Reset for two cycles, then check idle state
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_op_count", W'(op_count), W'(0));
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    check("rst_out_data", bus.out_data, 32'h0);

    // AND with latency check
    send(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF000F000, 1'b0);
    @(negedge clock);
    #1;
    check("lat_early", W'(bus.out_valid), W'(0));
    @(negedge clock);
    #1;
    check("lat_valid", W'(bus.out_valid), W'(1));
    drain();
    check("cnt_after_and", W'(op_count), W'(1));

    // Directed operation table, back to back
    foreach (vecs[i]) send(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].ed, vecs[i].ee);
    drain();
    check("cnt_after_table", W'(op_count), W'(13));

    // Backpressure: consumer stalls while six transactions are offered
    n_acc = 0;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(OP_XOR, 32'hA5A50000 | W'(i), 32'h0000FFFF, 32'h0, 32'hA5A5FFFF ^ W'(i), 1'b0);
      end
      begin
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("bp_accepts", W'(n_acc), W'(2));
        check("bp_in_ready", W'(bus.in_ready), W'(0));
        repeat (2) @(negedge clock);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_accepts_total", W'(n_acc), W'(6));
    check("cnt_after_bp", W'(op_count), W'(19));

    // Reset with two transactions in flight
    bus.out_ready = 1'b0;
    send(OP_OR, 32'h11111111, 32'h22222222, 32'h0, 32'h33333333, 1'b0);
    send(OP_OR, 32'h44444444, 32'h88888888, 32'h0, 32'hCCCCCCCC, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    q.delete();
    @(posedge clock);
    #1;
    check("midrst_out_valid", W'(bus.out_valid), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_op_count", W'(op_count), W'(0));
    check("midrst_in_ready", W'(bus.in_ready), W'(1));
    @(negedge clock);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    check("post_rst_idle", W'(busy | bus.out_valid), W'(0));
    send(OP_ANDN, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0, 32'hFFFF0000, 1'b0);
    drain();
    check("cnt_after_midrst", W'(op_count), W'(1));

    // Saturation on the 3-bit counter instance
    check("sat_start", W'(sat_count), W'(0));
    @(negedge clock);
    sif.in_valid = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    sif.in_valid = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    check("sat_count", W'(sat_count), W'(7));
    check("sat_idle", W'(sat_busy), W'(0));
    check("sat_last_data", sif.out_data, 32'h0F0F0F0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
